writeback: RTL and testbench
============================

Name: writeback

Overview:
- Final (WB) stage of the 5-stage MIPS pipeline; consumes the MEM/WB pipeline registers produced by the memory stage.
- Selects the result source: ALU result, or load data extracted, aligned and extended from the fetched memory word.
- Commits the result to the architectural 32x32 register file.
- Serves the decode stage's two combinational read ports (with WB->ID bypass) and drives a forwarding bus to execute.

Parameters:
- WORD_SIZE, 32, datapath width in bits; must be 32 for the byte/half lane logic.
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired to zero.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- alu_data_mem_wb  input  WORD_SIZE  ALU result; bits [1:0] give the load byte offset
- mem_data_mem_wb  input  WORD_SIZE  word read from data memory
- rd_en_mem_wb  input  1  destination write enable
- rd_addr_mem_wb  input  5  destination register
- rd_data_sel_mem_wb  input  1  result select: 1 = load data, 0 = ALU result
- ld_size_mem_wb  input  2  load size: 00 = word, 01 = half, 10 = byte, 11 = word
- ld_signed_mem_wb  input  1  1 = sign-extend sub-word loads, 0 = zero-extend
- rs_addr_id  input  5  decode read port A address
- rt_addr_id  input  5  decode read port B address
- rs_data_id  output  WORD_SIZE  read port A data (combinational)
- rt_data_id  output  WORD_SIZE  read port B data (combinational)
- wb_en  output  1  forwarding-bus valid: rd_en_mem_wb and rd_addr_mem_wb != 0
- wb_addr  output  5  forwarding-bus destination, equal to rd_addr_mem_wb
- wb_data  output  WORD_SIZE  forwarding-bus result (combinational)

Behaviour:
- Load extraction (combinational); off = alu_data_mem_wb[1:0]; byte lanes are little-endian (byte 0 = bits [7:0]).
  - Word: the full mem_data_mem_wb; off is ignored.
  - Half: selects bits [15:0] when off[1] = 0, bits [31:16] when off[1] = 1; off[0] is ignored (no alignment trap).
  - Byte: selects bits [8*off+7 : 8*off].
  - Sub-word results are extended to 32 bits per ld_signed_mem_wb.
- wb_data = rd_data_sel_mem_wb ? extracted load value : alu_data_mem_wb.
- Register write:
  - On a rising clk edge with rst = 0 and wb_en = 1: regs[rd_addr_mem_wb] <= wb_data.
  - Writes to address 0 are discarded.
- Reads:
  - Address 0 returns 0.
  - Otherwise, when wb_en = 1 and the address equals wb_addr, the port returns wb_data (same-cycle WB->ID bypass; zero added latency).
  - Otherwise the port returns the stored register.
  - Both ports may hit the bypass at the same time.
- Latency: a result is visible on the ID read ports in the cycle it is presented, and in storage from the following edge.
- Reset: rst = 1 at a rising edge clears every register to 0 and suppresses any write in that same cycle (reset wins over write).
  - While rst is held, the read ports still apply the bypass from the live inputs; upstream holds rd_en_mem_wb low during reset.
- There are no undefined outputs after the first reset edge.
- Never stalls; there is no handshake. One result is accepted per cycle unconditionally.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output retired_count (32 bits) and input retire_valid_mem_wb (1 bit; marks a real, non-bubble instruction).
  - The counter increments by 1 at each rising edge with retire_valid_mem_wb = 1 and rst = 0.
  - It wraps from 0xFFFFFFFF to 0 and clears to 0 on rst.
- Undefined:
  - Neither port exists and no counter logic is generated.
  - All other behaviour is identical.

Test Plan:
- Reset, then write reg 5 <= 0x12345678 (ALU path).
  - Same cycle: rs_addr_id = 5 returns 0x12345678 via bypass.
  - Next cycle, with wb_en = 0: still returns 0x12345678 from storage.
- Byte load, mem_data = 0x80FF7F01, signed.
  - off 0 -> 0x00000001; off 1 -> 0x0000007F; off 2 -> 0xFFFFFFFF; off 3 -> 0xFFFFFF80.
  - Unsigned, off 3 -> 0x00000080.
- Half load, mem_data = 0x8001F00F.
  - Signed: off 0 -> 0xFFFFF00F; off 2 -> 0xFFFF8001; off 3 -> 0xFFFF8001.
  - Unsigned, off 2 -> 0x00008001.
- Write to r0 with data 0xDEADBEEF, rd_en = 1.
  - wb_en = 0; reading r0 returns 0 in that cycle and the next.
- Write reg 7 = 0xA5A5A5A5; then assert rst together with a write of reg 8 = 0x1.
  - After the edge: r7 = 0 and r8 = 0.
  - Both ports reading 7 and 8 in the same cycle return 0.
- With WB_RETIRE_COUNT_EN defined:
  - 3 valid retires, 1 bubble, then 2 valid -> retired_count = 5.
  - Preload via 2^32-1 valid retires (or force), then one more valid retire -> retired_count = 0.

Source files
------------

// File: rtl/writeback.sv
// MIPS WB stage: load extraction/extension, result select, 32x32 register file
// with WB->ID bypass on two read ports. Optional retire counter: WB_RETIRE_COUNT_EN.
module writeback_rd_port #(
  parameter int WORD_SIZE = 32
) (
  input  logic [4:0]           addr,
  input  logic [WORD_SIZE-1:0] reg_q,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic [WORD_SIZE-1:0] data
);
  always_comb begin
    data = reg_q;
    if (addr == 5'd0)                    data = '0;
    else if (wb_en && (addr == wb_addr)) data = wb_data;
  end
endmodule

module writeback #(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] alu_data_mem_wb,
  input  logic [WORD_SIZE-1:0] mem_data_mem_wb,
  input  logic                 rd_en_mem_wb,
  input  logic [4:0]           rd_addr_mem_wb,
  input  logic                 rd_data_sel_mem_wb,
  input  logic [1:0]           ld_size_mem_wb,
  input  logic                 ld_signed_mem_wb,
  input  logic [4:0]           rs_addr_id,
  input  logic [4:0]           rt_addr_id,
  output logic [WORD_SIZE-1:0] rs_data_id,
  output logic [WORD_SIZE-1:0] rt_data_id,
`ifdef WB_RETIRE_COUNT_EN
  input  logic                 retire_valid_mem_wb,
  output logic [31:0]          retired_count,
`endif
  output logic                 wb_en,
  output logic [4:0]           wb_addr,
  output logic [WORD_SIZE-1:0] wb_data
);
  localparam int NUM_RD = 2;

  typedef struct packed {
    logic                 en;
    logic [4:0]           addr;
    logic [WORD_SIZE-1:0] data;
  } wb_req_t;

  wb_req_t              wb_req;
  logic [3:0][7:0]      mem_b;
  logic [1:0]           off;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [WORD_SIZE-1:0] ld_val;

  assign off      = alu_data_mem_wb[1:0];
  assign mem_b    = mem_data_mem_wb;
  assign byte_sel = mem_b[off];
  // off[0] is ignored for halves: misaligned halves read the containing half.
  assign half_sel = off[1] ? mem_data_mem_wb[31:16] : mem_data_mem_wb[15:0];

  always_comb begin
    ld_val = mem_data_mem_wb;
    case (ld_size_mem_wb)
      2'b01:   ld_val = {{(WORD_SIZE-16){ld_signed_mem_wb & half_sel[15]}}, half_sel};
      2'b10:   ld_val = {{(WORD_SIZE-8){ld_signed_mem_wb & byte_sel[7]}}, byte_sel};
      default: ld_val = mem_data_mem_wb;
    endcase
  end

  assign wb_req.en   = rd_en_mem_wb && (rd_addr_mem_wb != 5'd0);
  assign wb_req.addr = rd_addr_mem_wb;
  assign wb_req.data = rd_data_sel_mem_wb ? ld_val : alu_data_mem_wb;

  assign wb_en   = wb_req.en;
  assign wb_addr = wb_req.addr;
  assign wb_data = wb_req.data;

  logic [WORD_SIZE-1:0] regs [REG_COUNT];

  // Reset wins over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_req.en) begin
      regs[wb_req.addr] <= wb_req.data;
    end
  end

  logic [NUM_RD-1:0][4:0]           rd_addr;
  logic [NUM_RD-1:0][WORD_SIZE-1:0] rd_data;

  assign rd_addr = {rt_addr_id, rs_addr_id};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    writeback_rd_port #(.WORD_SIZE(WORD_SIZE)) u_rd (
      .addr    (rd_addr[g]),
      .reg_q   (regs[rd_addr[g]]),
      .wb_en   (wb_req.en),
      .wb_addr (wb_req.addr),
      .wb_data (wb_req.data),
      .data    (rd_data[g])
    );
  end

  assign rs_data_id = rd_data[0];
  assign rt_data_id = rd_data[1];

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                      retired_count <= '0;
    else if (retire_valid_mem_wb) retired_count <= retired_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_writeback.sv
// Randomized + directed bench for writeback against a behavioural register-file model.
module tb_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_data, mem_data;
  logic        rd_en, rd_sel, ld_signed;
  logic [4:0]  rd_addr, rs_addr, rt_addr;
  logic [1:0]  ld_size;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
`ifdef WB_RETIRE_COUNT_EN
  logic        retire_valid = 1'b0;
  logic [31:0] retired_count;
  logic [31:0] mcnt = '0;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [31:0] mregs [32];

  always #5 clk = ~clk;

  writeback dut (
    .clk                (clk),
    .rst                (rst),
    .alu_data_mem_wb    (alu_data),
    .mem_data_mem_wb    (mem_data),
    .rd_en_mem_wb       (rd_en),
    .rd_addr_mem_wb     (rd_addr),
    .rd_data_sel_mem_wb (rd_sel),
    .ld_size_mem_wb     (ld_size),
    .ld_signed_mem_wb   (ld_signed),
    .rs_addr_id         (rs_addr),
    .rt_addr_id         (rt_addr),
    .rs_data_id         (rs_data),
    .rt_data_id         (rt_data),
`ifdef WB_RETIRE_COUNT_EN
    .retire_valid_mem_wb(retire_valid),
    .retired_count      (retired_count),
`endif
    .wb_en              (wb_en),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] mem, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'd1) begin
      v = (mem >> (16 * int'(off[1]))) & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else if (sz == 2'd2) begin
      v = (mem >> (8 * int'(off))) & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  function automatic logic exp_en();
    return rd_en && (rd_addr != 5'd0);
  endfunction

  function automatic logic [31:0] exp_data();
    return rd_sel ? ld_model(mem_data, alu_data[1:0], ld_size, ld_signed) : alu_data;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exp_en() && a == rd_addr) return exp_data();
    return mregs[a];
  endfunction

  // Model state follows the architectural rules at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (exp_en()) begin
      mregs[rd_addr] = exp_data();
    end
`ifdef WB_RETIRE_COUNT_EN
    if (rst) mcnt = 32'd0;
    else if (retire_valid) mcnt = mcnt + 32'd1;
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rs_data", rs_data, exp_read(rs_addr));
      check("rt_data", rt_data, exp_read(rt_addr));
      check("wb_en", {31'd0, wb_en}, {31'd0, exp_en()});
      check("wb_addr", {27'd0, wb_addr}, {27'd0, rd_addr});
      check("wb_data", wb_data, exp_data());
`ifdef WB_RETIRE_COUNT_EN
      check("retired_count", retired_count, mcnt);
`endif
    end
  end

  task automatic drive(input logic [31:0] alu, input logic [31:0] mem, input logic en,
                       input logic [4:0] addr, input logic sel, input logic [1:0] sz,
                       input logic sg, input logic [4:0] ra, input logic [4:0] rb,
                       input logic r);
    @(posedge clk); #1;
    alu_data = alu; mem_data = mem; rd_en = en; rd_addr = addr; rd_sel = sel;
    ld_size = sz; ld_signed = sg; rs_addr = ra; rt_addr = rb; rst = r;
  endtask

  // Directed load table: {mem, off, size, signed, expected}
  logic [31:0] t_mem [9] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                             32'h80FF7F01, 32'h8001F00F, 32'h8001F00F, 32'h8001F00F,
                             32'h8001F00F};
  logic [1:0]  t_off [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2, 2'd3, 2'd2};
  logic [1:0]  t_sz  [9] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
  logic        t_sg  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] t_exp [9] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                             32'h00000080, 32'hFFFFF00F, 32'hFFFF8001, 32'hFFFF8001,
                             32'h00008001};

  initial begin
    rst = 1'b1; alu_data = '0; mem_data = '0; rd_en = 1'b0; rd_addr = '0;
    rd_sel = 1'b0; ld_size = '0; ld_signed = 1'b0; rs_addr = '0; rt_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd3, 5'd31, 1'b0);
    @(negedge clk);
    check("reset_r3", rs_data, 32'd0);
    check("reset_r31", rt_data, 32'd0);

    // ALU write with same-cycle bypass, then from storage
    drive(32'h12345678, 32'h0, 1'b1, 5'd5, 1'b0, 2'd0, 1'b0, 5'd5, 5'd5, 1'b0);
    @(negedge clk);
    check("bypass_r5", rs_data, 32'h12345678);
    check("bypass_r5_rt", rt_data, 32'h12345678);
    drive(32'h0, 32'h0, 1'b0, 5'd5, 1'b0, 2'd0, 1'b0, 5'd5, 5'd0, 1'b0);
    @(negedge clk);
    check("stored_r5", rs_data, 32'h12345678);

    // Load extraction table, committed to r9 and read back via bypass
    for (int i = 0; i < 9; i++) begin
      drive({30'd0, t_off[i]}, t_mem[i], 1'b1, 5'd9, 1'b1, t_sz[i], t_sg[i], 5'd9, 5'd5, 1'b0);
      @(negedge clk);
      check($sformatf("load%0d", i), wb_data, t_exp[i]);
      check($sformatf("load%0d_rs", i), rs_data, t_exp[i]);
    end

    // Writes to r0 are discarded
    drive(32'hDEADBEEF, 32'h0, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("r0_wb_en", {31'd0, wb_en}, 32'd0);
    check("r0_same", rs_data, 32'd0);
    drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("r0_next", rs_data, 32'd0);

    // Reset beats a concurrent write; bypass still visible while rst is high
    drive(32'hA5A5A5A5, 32'h0, 1'b1, 5'd7, 1'b0, 2'd0, 1'b0, 5'd7, 5'd8, 1'b0);
    drive(32'h00000001, 32'h0, 1'b1, 5'd8, 1'b0, 2'd0, 1'b0, 5'd7, 5'd8, 1'b1);
    @(negedge clk);
    check("rst_cycle_r7", rs_data, 32'hA5A5A5A5);
    check("rst_cycle_r8", rt_data, 32'h00000001);
    drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd7, 5'd8, 1'b0);
    @(negedge clk);
    check("post_rst_r7", rs_data, 32'd0);
    check("post_rst_r8", rt_data, 32'd0);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 600; n++) begin
      drive($urandom, $urandom, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), ($urandom_range(0, 60) == 0));
`ifdef WB_RETIRE_COUNT_EN
      retire_valid = 1'($urandom);
`endif
    end

`ifdef WB_RETIRE_COUNT_EN
    drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    retire_valid = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 retire_valid = (i != 3);
    end
    @(posedge clk); #1 retire_valid = 1'b0;
    @(negedge clk);
    check("retire_5", retired_count, 32'd5);
    force dut.retired_count = 32'hFFFF_FFFF;
    mcnt = 32'hFFFF_FFFF;
    @(posedge clk); #1 release dut.retired_count;
    retire_valid = 1'b1;
    @(posedge clk); #1 retire_valid = 1'b0;
    @(negedge clk);
    check("retire_wrap", retired_count, 32'd0);
`endif

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
